dma_desc_sched: RTL and testbench

- Descriptor scheduler between the DMA CSR block and the DMA transfer engine.
- Buffers scatter-transfer descriptors (src/dst/len/last) pushed by the CSR block in a FIFO. Issues them one at a time to the engine and tracks per-block completion.
- Raises a single interrupt to the L1 scheduler when the chain's last block completes or any block errors. On error, discards the remaining queued descriptors.

---
 rtl/dma_pkg.sv | 24 ++
 rtl/dma_desc_fifo.sv | 55 +++++
 rtl/dma_desc_sched.sv | 155 +++++++++++++++
 tb/tb_dma_desc_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor path: descriptor record and scheduler states.
package dma_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_LEN_W  = 32;
    localparam int DMA_ESRC_W = 4;   // width of the engine error-source code

    // Default descriptor layout; the scheduler re-derives it from its own parameters.
    typedef struct packed {
        logic [DMA_ADDR_W-1:0] src;
        logic [DMA_ADDR_W-1:0] dst;
        logic [DMA_LEN_W-1:0]  len;
        logic                  last;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FLUSH,
        IRQ
    } sched_state_e;

endpackage

// File: rtl/dma_desc_fifo.sv
// Synchronous descriptor FIFO with push/pop/flush and occupancy count.
// Head entry is presented combinationally on rdata; pointers wrap modulo DEPTH.
module dma_desc_fifo
    import dma_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = desc_t
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         wdata,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointer and occupancy tracking; flush drops everything queued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: queues CSR-pushed descriptors, issues them one at a time
// to the transfer engine, counts completions and raises one irq per chain end or error.
module dma_desc_sched
    import dma_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int LEN_W  = DMA_LEN_W,
    parameter int ESRC_W = DMA_ESRC_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [ADDR_W-1:0]        push_src_i,
    input  logic [ADDR_W-1:0]        push_dst_i,
    input  logic [LEN_W-1:0]         push_len_i,
    input  logic                     push_last_i,
    output logic                     eng_valid_o,
    input  logic                     eng_ready_i,
    output logic [ADDR_W-1:0]        eng_src_o,
    output logic [ADDR_W-1:0]        eng_dst_o,
    output logic [LEN_W-1:0]         eng_len_o,
    input  logic                     eng_done_i,
    input  logic                     eng_error_i,
    input  logic [ADDR_W-1:0]        eng_err_addr_i,
    input  logic [ESRC_W-1:0]        eng_err_src_i,
    output logic                     irq_o,
    input  logic                     irq_clr_i,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     stat_error_o,
    output logic [ADDR_W-1:0]        err_addr_o,
    output logic [ESRC_W-1:0]        err_src_o,
    output logic [CNT_W-1:0]         blk_cnt_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [LEN_W-1:0]  len;
        logic              last;
    } sdesc_t;

    sched_state_e             state;
    sdesc_t                   head;
    sdesc_t                   wdesc;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     push;
    logic                     pop;
    logic                     has_desc;
    logic                     head_zero;
    logic                     last_q;

    assign wdesc.src  = push_src_i;
    assign wdesc.dst  = push_dst_i;
    assign wdesc.len  = push_len_i;
    assign wdesc.last = push_last_i;

    assign has_desc  = (count != '0);
    assign head_zero = (head.len == '0);

    // Queue stays closed during the flush cycle so nothing lands in a FIFO being cleared.
    assign push_ready_o = !full && (state != FLUSH);
    assign push         = push_valid_i && push_ready_o;
    // Zero-length descriptors retire straight from the head without involving the engine.
    assign pop          = ((state == ISSUE) && eng_ready_i) ||
                          ((state == IDLE) && has_desc && head_zero);

    assign eng_valid_o  = (state == ISSUE);
    assign eng_src_o    = eng_valid_o ? head.src : '0;
    assign eng_dst_o    = eng_valid_o ? head.dst : '0;
    assign eng_len_o    = eng_valid_o ? head.len : '0;
    assign irq_o        = (state == IRQ);
    assign busy_o       = (state inside {ISSUE, WAIT, FLUSH}) || has_desc;
    assign fifo_count_o = count;

    dma_desc_fifo #(
        .DEPTH (DEPTH),
        .T     (sdesc_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (state == FLUSH),
        .wdata (wdesc),
        .rdata (head),
        .count (count),
        .full  (full)
    );

    // Scheduler FSM with completion counter and error capture.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            last_q       <= 1'b0;
            blk_cnt_o    <= '0;
            stat_error_o <= 1'b0;
            err_addr_o   <= '0;
            err_src_o    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (has_desc) begin
                        if (!head_zero) begin
                            state <= ISSUE;
                        end else begin
                            if (blk_cnt_o != '1) blk_cnt_o <= blk_cnt_o + 1'b1;
                            if (head.last) begin
                                stat_error_o <= 1'b0;
                                state        <= IRQ;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (eng_ready_i) begin
                        last_q <= head.last;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_done_i) begin
                        if (eng_error_i) begin
                            err_addr_o   <= eng_err_addr_i;
                            err_src_o    <= eng_err_src_i;
                            stat_error_o <= 1'b1;
                            state        <= FLUSH;
                        end else begin
                            if (blk_cnt_o != '1) blk_cnt_o <= blk_cnt_o + 1'b1;
                            if (last_q) begin
                                stat_error_o <= 1'b0;
                                state        <= IRQ;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                FLUSH: state <= IRQ;
                IRQ: begin
                    if (irq_clr_i) begin
                        blk_cnt_o <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Bench for dma_desc_sched: table of single-descriptor transactions plus
// hand-written chain / error / fill / reset sequences, with an engine responder
// that checks issued descriptors against a scoreboard queue.
module tb_dma_desc_sched;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;
    localparam int ESRC_W = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              push_valid_i = 1'b0;
    logic              push_ready_o;
    logic [ADDR_W-1:0] push_src_i = '0;
    logic [ADDR_W-1:0] push_dst_i = '0;
    logic [LEN_W-1:0]  push_len_i = '0;
    logic              push_last_i = 1'b0;
    logic              eng_valid_o;
    logic              eng_ready_i = 1'b0;
    logic [ADDR_W-1:0] eng_src_o;
    logic [ADDR_W-1:0] eng_dst_o;
    logic [LEN_W-1:0]  eng_len_o;
    logic              eng_done_i = 1'b0;
    logic              eng_error_i = 1'b0;
    logic [ADDR_W-1:0] eng_err_addr_i = '0;
    logic [ESRC_W-1:0] eng_err_src_i = '0;
    logic              irq_o;
    logic              irq_clr_i = 1'b0;
    logic              busy_o;
    logic [$clog2(DEPTH):0] fifo_count_o;
    logic              stat_error_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic [ESRC_W-1:0] err_src_o;
    logic [CNT_W-1:0]  blk_cnt_o;

    always #5 clk = ~clk;

    dma_desc_sched #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ESRC_W(ESRC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_src_i(push_src_i), .push_dst_i(push_dst_i),
        .push_len_i(push_len_i), .push_last_i(push_last_i),
        .eng_valid_o(eng_valid_o), .eng_ready_i(eng_ready_i),
        .eng_src_o(eng_src_o), .eng_dst_o(eng_dst_o), .eng_len_o(eng_len_o),
        .eng_done_i(eng_done_i), .eng_error_i(eng_error_i),
        .eng_err_addr_i(eng_err_addr_i), .eng_err_src_i(eng_err_src_i),
        .irq_o(irq_o), .irq_clr_i(irq_clr_i), .busy_o(busy_o),
        .fifo_count_o(fifo_count_o), .stat_error_o(stat_error_o),
        .err_addr_o(err_addr_o), .err_src_o(err_src_o), .blk_cnt_o(blk_cnt_o)
    );

    typedef struct { logic [31:0] src, dst, len; } iss_t;
    iss_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // engine controls (written by main only)
    bit          eng_en    = 1'b1;
    int          eng_stall = 0;
    int          eng_dly   = 1;
    int          err_blk   = -1;
    logic [31:0] e_addr    = '0;
    logic [3:0]  e_src     = '0;
    // engine observations (written by engine only)
    int eng_blk  = 0;
    int vld_cyc  = 0;
    int done_cyc = 0;
    // main-owned
    int push_cyc = 0;
    int acc_blk  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected event within bound", nm);
    endtask

    // Engine responder: optional stall, accept, done pulse after eng_dly cycles.
    initial begin : engine
        logic [31:0] s_src, s_dst, s_len;
        iss_t e;
        forever begin
            @(negedge clk);
            eng_ready_i = 1'b0;
            eng_done_i  = 1'b0;
            eng_error_i = 1'b0;
            if (eng_en && rstn && eng_valid_o) begin
                vld_cyc = cyc;
                s_src = eng_src_o; s_dst = eng_dst_o; s_len = eng_len_o;
                for (int s = 0; s < eng_stall; s++) begin
                    @(negedge clk);
                    chk("stall_stable", {eng_valid_o, eng_src_o, eng_dst_o, eng_len_o},
                        {1'b1, s_src, s_dst, s_len});
                end
                eng_ready_i = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_issue: got src %0h expected no issue", s_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_desc", {s_src, s_dst, s_len}, {e.src, e.dst, e.len});
                end
                eng_blk++;
                @(negedge clk);
                eng_ready_i = 1'b0;
                for (int d = 1; d < eng_dly; d++) @(negedge clk);
                eng_done_i     = 1'b1;
                eng_error_i    = (eng_blk == err_blk);
                eng_err_addr_i = e_addr;
                eng_err_src_i  = e_src;
                done_cyc       = cyc;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the descriptor is accepted.
    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                             input logic lst, input bit exp_issue);
        push_src_i = s; push_dst_i = d; push_len_i = l; push_last_i = lst;
        push_valid_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (push_ready_o) break;
            @(negedge clk);
        end
        if (!push_ready_o) begin
            timeout("push_accept");
            push_valid_i = 1'b0;
            return;
        end
        push_cyc = cyc;
        acc_blk  = eng_blk;
        if (exp_issue && l != 0) exp_q.push_back('{s, d, l});
        @(negedge clk);
        push_valid_i = 1'b0;
    endtask

    task automatic wait_irq(output int at);
        at = -1;
        for (int i = 0; i < 400; i++) begin
            if (irq_o) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        timeout("irq_wait");
    endtask

    task automatic clear_irq();
        irq_clr_i = 1'b1;
        @(negedge clk);
        irq_clr_i = 1'b0;
        chk("irq_cleared", irq_o, 1'b0);
        chk("blk_cnt_cleared", blk_cnt_o, '0);
    endtask

    typedef struct {
        logic [31:0] src, dst, len;
        int          stall, dly;
        bit          err;
        logic [31:0] eaddr;
        logic [3:0]  esrc;
        int          lat;
        logic        stat;
        logic [15:0] blk;
        logic [31:0] x_eaddr;
        logic [3:0]  x_esrc;
    } vec_t;

    vec_t tbl[5];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int at, base, rst_cyc;
        bit irq_seen;

        tbl[0] = '{32'h1000, 32'h2000, 32'd64, 0, 10, 1'b0, 32'h0, 4'h0, 1, 1'b0, 16'd1, 32'h0, 4'h0};
        tbl[1] = '{32'h3000, 32'h4000, 32'd128, 3, 4, 1'b0, 32'h0, 4'h0, 1, 1'b0, 16'd1, 32'h0, 4'h0};
        tbl[2] = '{32'h5000, 32'h6000, 32'd16, 1, 2, 1'b1, 32'hBEEF0100, 4'h5, 2, 1'b1, 16'd0, 32'hBEEF0100, 4'h5};
        tbl[3] = '{32'h7000, 32'h8000, 32'd0, 0, 1, 1'b0, 32'h0, 4'h0, 2, 1'b0, 16'd1, 32'hBEEF0100, 4'h5};
        tbl[4] = '{32'hFFFFFFF0, 32'h0, 32'hFFFFFFFF, 0, 1, 1'b0, 32'h0, 4'h0, 1, 1'b0, 16'd1, 32'hBEEF0100, 4'h5};

        // reset state
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_push_ready", push_ready_o, 1'b1);
        chk("rst_outputs", {eng_valid_o, irq_o, busy_o, stat_error_o, fifo_count_o, blk_cnt_o},
            '0);
        chk("rst_eng_data", {eng_src_o, eng_dst_o, eng_len_o}, '0);
        chk("rst_err_regs", {err_addr_o, err_src_o}, '0);

        // single-descriptor table
        foreach (tbl[i]) begin
            eng_stall = tbl[i].stall;
            eng_dly   = tbl[i].dly;
            err_blk   = tbl[i].err ? eng_blk + 1 : -1;
            e_addr    = tbl[i].eaddr;
            e_src     = tbl[i].esrc;
            push_desc(tbl[i].src, tbl[i].dst, tbl[i].len, 1'b1, 1'b1);
            wait_irq(at);
            chk($sformatf("v%0d_irq_lat", i), at - ((tbl[i].len == 0) ? push_cyc : done_cyc),
                tbl[i].lat);
            if (tbl[i].len != 0)
                chk($sformatf("v%0d_vld_lat", i), vld_cyc - push_cyc, 2);
            chk($sformatf("v%0d_stat", i), stat_error_o, tbl[i].stat);
            chk($sformatf("v%0d_blk", i), blk_cnt_o, tbl[i].blk);
            chk($sformatf("v%0d_err", i), {err_addr_o, err_src_o}, {tbl[i].x_eaddr, tbl[i].x_esrc});
            chk($sformatf("v%0d_fifo", i), fifo_count_o, '0);
            clear_irq();
            chk($sformatf("v%0d_sb_empty", i), exp_q.size(), 0);
        end

        // 3-block chain with 5-cycle engine stall per block
        eng_stall = 5; eng_dly = 3; err_blk = -1;
        base = eng_blk;
        push_desc(32'hA000, 32'hB000, 32'd32, 1'b0, 1'b1);
        push_desc(32'hA100, 32'hB100, 32'd48, 1'b0, 1'b1);
        push_desc(32'hA200, 32'hB200, 32'd80, 1'b1, 1'b1);
        wait_irq(at);
        chk("chain_irq_after_third", eng_blk - base, 3);
        chk("chain_irq_lat", at - done_cyc, 1);
        chk("chain_blk", blk_cnt_o, 16'd3);
        chk("chain_stat", stat_error_o, 1'b0);
        clear_irq();
        irq_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            irq_seen |= irq_o;
        end
        chk("chain_single_irq", irq_seen, 1'b0);
        chk("chain_sb_empty", exp_q.size(), 0);

        // error on block 2 of 4: remainder discarded
        eng_stall = 0; eng_dly = 3;
        base = eng_blk;
        err_blk = base + 2; e_addr = 32'hDEAD0040; e_src = 4'h3;
        for (int k = 0; k < 4; k++)
            push_desc(32'hC000 + 32'(k) * 32'h100, 32'hD000 + 32'(k) * 32'h100, 32'd16,
                      k == 3, k < 2);
        wait_irq(at);
        chk("err_irq_lat", at - done_cyc, 2);
        chk("err_fifo_flushed", fifo_count_o, '0);
        chk("err_stat", stat_error_o, 1'b1);
        chk("err_addr", err_addr_o, 32'hDEAD0040);
        chk("err_src", err_src_o, 4'h3);
        chk("err_blk", blk_cnt_o, 16'd1);
        clear_irq();
        repeat (10) @(negedge clk);
        chk("err_no_more_issue", eng_blk - base, 2);
        chk("err_idle", {busy_o, irq_o}, 2'b00);
        chk("err_sb_empty", exp_q.size(), 0);

        // fill the FIFO with the engine held off
        eng_en = 1'b0; eng_stall = 0; eng_dly = 1; err_blk = -1;
        base = eng_blk;
        for (int k = 0; k < DEPTH; k++)
            push_desc(32'hE000 + 32'(k), 32'hF000 + 32'(k), 32'd8, 1'b0, 1'b1);
        chk("fill_count", fifo_count_o, 4'd8);
        chk("fill_ready_low", push_ready_o, 1'b0);
        push_src_i = 32'hE999; push_dst_i = 32'hF999; push_len_i = 32'd8; push_last_i = 1'b1;
        push_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("fill_ninth_stalls", {fifo_count_o, push_ready_o}, {4'd8, 1'b0});
        eng_en = 1'b1;
        push_desc(32'hE999, 32'hF999, 32'd8, 1'b1, 1'b1);
        chk("fill_ninth_after_accept", acc_blk - base, 1);
        wait_irq(at);
        chk("fill_blk", blk_cnt_o, 16'd9);
        clear_irq();
        chk("fill_sb_empty", exp_q.size(), 0);

        // reset while WAIT with 2 queued; late done must not raise irq
        eng_stall = 0; eng_dly = 12; err_blk = -1;
        push_desc(32'h1100, 32'h2200, 32'd4, 1'b0, 1'b1);
        push_desc(32'h1101, 32'h2201, 32'd4, 1'b0, 1'b0);
        push_desc(32'h1102, 32'h2202, 32'd4, 1'b1, 1'b0);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            if (busy_o && !eng_valid_o && fifo_count_o == 2) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        if (at < 0) timeout("reach_wait");
        rstn = 1'b0;
        rst_cyc = cyc;
        #1;
        chk("midrst_outputs", {eng_valid_o, irq_o, busy_o, stat_error_o, fifo_count_o, blk_cnt_o},
            '0);
        chk("midrst_data", {eng_src_o, eng_dst_o, eng_len_o, err_addr_o, err_src_o}, '0);
        chk("midrst_push_ready", push_ready_o, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        irq_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            irq_seen |= irq_o;
        end
        chk("late_done_seen", done_cyc > rst_cyc, 1'b1);
        chk("late_done_no_irq", irq_seen, 1'b0);
        chk("late_done_quiet", {busy_o, fifo_count_o, blk_cnt_o}, '0);
        chk("rst_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
